// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush controller for the 5-stage RV32I pipe: load-use bubbles, redirect flushes,
// I/D memory wait freeze with early-response capture. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             rs1_used_ID,
   input  logic             rs2_used_ID,
   input  logic             mem_read_EX,
   input  logic [4:0]       rd_EX,
   input  logic             br_taken_EX,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             pc_load,
   output logic             load_IF_ID,
   output logic             load_ID_EX,
   output logic             load_EX_MEM,
   output logic             load_MEM_WB,
   output logic             bubble_ID_EX,
   output logic             flush_IF_ID,
   output logic             ibuf_load,
   output logic             ibuf_sel,
   output logic             dbuf_load,
   output logic             dbuf_sel,
   output logic             imem_read_mask,
   output logic             dmem_req_mask
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] BUBBLE   = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;
   localparam logic [1:0] LU_INIT  = 2'(LU_BUBBLES - 1);

   logic [1:0] state_q, state_d;
   logic [1:0] bub_cnt_q, bub_cnt_d;
   logic       if_done_q, if_done_d;
   logic       mem_done_q, mem_done_d;
   logic       i_wait, d_wait, stall, lu_hazard;

   assign i_wait = imem_read & ~imem_resp & ~if_done_q;
   assign d_wait = dmem_req & ~dmem_resp & ~mem_done_q;
   assign stall  = i_wait | d_wait;

   assign lu_hazard = mem_read_EX & (rd_EX != 5'd0) &
                      ((rs1_used_ID & (rs1_ID == rd_EX)) | (rs2_used_ID & (rs2_ID == rd_EX)));

   always_comb begin
      pc_load        = 1'b0;
      load_IF_ID     = 1'b0;
      load_ID_EX     = 1'b0;
      load_EX_MEM    = 1'b0;
      load_MEM_WB    = 1'b0;
      bubble_ID_EX   = 1'b0;
      flush_IF_ID    = 1'b0;
      ibuf_load      = 1'b0;
      ibuf_sel       = 1'b0;
      dbuf_load      = 1'b0;
      dbuf_sel       = 1'b0;
      imem_read_mask = 1'b0;
      dmem_req_mask  = 1'b0;
      state_d        = state_q;
      bub_cnt_d      = bub_cnt_q;
      if_done_d      = if_done_q;
      mem_done_d     = mem_done_q;
      // Outputs are forced low while reset is held, even though they are combinational.
      if (!rst) begin
         imem_read_mask = if_done_q;
         dmem_req_mask  = mem_done_q;
         if (stall) begin
            ibuf_load  = imem_resp;
            dbuf_load  = dmem_resp;
            if_done_d  = if_done_q | imem_resp;
            mem_done_d = mem_done_q | dmem_resp;
            state_d    = MEM_WAIT;
         end else begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            ibuf_sel   = if_done_q;
            dbuf_sel   = mem_done_q;
            if (br_taken_EX) begin
               pc_load      = 1'b1;
               load_IF_ID   = 1'b1;
               load_ID_EX   = 1'b1;
               load_EX_MEM  = 1'b1;
               load_MEM_WB  = 1'b1;
               bubble_ID_EX = 1'b1;
               flush_IF_ID  = 1'b1;
               bub_cnt_d    = 2'd0;
               state_d      = RUN;
            end else if (state_q == BUBBLE || lu_hazard) begin
               // ID and PC hold; ID/EX takes a NOP while the older stages drain.
               load_ID_EX   = 1'b1;
               load_EX_MEM  = 1'b1;
               load_MEM_WB  = 1'b1;
               bubble_ID_EX = 1'b1;
               if (state_q == BUBBLE) begin
                  bub_cnt_d = bub_cnt_q - 2'd1;
                  if (bub_cnt_q <= 2'd1) state_d = RUN;
               end else if (LU_BUBBLES > 1) begin
                  bub_cnt_d = LU_INIT;
                  state_d   = BUBBLE;
               end else begin
                  state_d = RUN;
               end
            end else begin
               pc_load     = 1'b1;
               load_IF_ID  = 1'b1;
               load_ID_EX  = 1'b1;
               load_EX_MEM = 1'b1;
               load_MEM_WB = 1'b1;
               state_d     = RUN;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         bub_cnt_q  <= 2'd0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bub_cnt_q  <= bub_cnt_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
      end
   end

`ifdef HAZARD_PERF_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
      return v;
   endfunction

   logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

   // Bubble count covers load-use NOP cycles only; redirect cycles are counted as flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         stall_cnt_q  <= sat_inc(stall_cnt_q, stall);
         bubble_cnt_q <= sat_inc(bubble_cnt_q, bubble_ID_EX & ~flush_IF_ID);
         flush_cnt_q  <= sat_inc(flush_cnt_q, flush_IF_ID);
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`else
   logic unused_cfg;
   assign unused_cfg = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LU_BUBBLES=1 and 3) share the stimulus.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] rs1_ID, rs2_ID, rd_EX;
   logic rs1_used_ID, rs2_used_ID, mem_read_EX, br_taken_EX;
   logic imem_read, imem_resp, dmem_req, dmem_resp;

   logic [12:0] out1, out3;
   logic [12:0] q1[$];
   logic [12:0] q3[$];
   int checks = 0;
   int failures = 0;
   bit done = 0;

   // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB, bubble, flush, ibuf_load, ibuf_sel, dbuf_load, dbuf_sel, imask, dmask}
   localparam logic [12:0] ZERO  = 13'b00000_00_00_00_00;
   localparam logic [12:0] NORM  = 13'b11111_00_00_00_00;
   localparam logic [12:0] LU    = 13'b00111_10_00_00_00;
   localparam logic [12:0] REDIR = 13'b11111_11_00_00_00;

   always #5 clk = ~clk;

   hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .mem_read_EX(mem_read_EX), .rd_EX(rd_EX), .br_taken_EX(br_taken_EX),
      .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .pc_load(out1[12]), .load_IF_ID(out1[11]), .load_ID_EX(out1[10]),
      .load_EX_MEM(out1[9]), .load_MEM_WB(out1[8]), .bubble_ID_EX(out1[7]),
      .flush_IF_ID(out1[6]), .ibuf_load(out1[5]), .ibuf_sel(out1[4]),
      .dbuf_load(out1[3]), .dbuf_sel(out1[2]), .imem_read_mask(out1[1]), .dmem_req_mask(out1[0])
   );

   hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(32)) dut3 (
      .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .mem_read_EX(mem_read_EX), .rd_EX(rd_EX), .br_taken_EX(br_taken_EX),
      .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .pc_load(out3[12]), .load_IF_ID(out3[11]), .load_ID_EX(out3[10]),
      .load_EX_MEM(out3[9]), .load_MEM_WB(out3[8]), .bubble_ID_EX(out3[7]),
      .flush_IF_ID(out3[6]), .ibuf_load(out3[5]), .ibuf_sel(out3[4]),
      .dbuf_load(out3[3]), .dbuf_sel(out3[2]), .imem_read_mask(out3[1]), .dmem_req_mask(out3[0])
   );

   task automatic idle();
      rs1_ID = 5'd1; rs2_ID = 5'd2; rd_EX = 5'd9;
      rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; mem_read_EX = 1'b0; br_taken_EX = 1'b0;
      imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
   endtask

   // lw x5 in EX, add x6,x5,x1 in ID
   task automatic set_lu();
      mem_read_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; rs2_ID = 5'd1;
      rs1_used_ID = 1'b1; rs2_used_ID = 1'b1;
   endtask

   // Inputs are already applied; queue expectations, then advance to 1 ns after the next edge.
   task automatic go(input logic c1, input logic [12:0] e1, input logic c3, input logic [12:0] e3);
      if (c1) q1.push_back(e1);
      if (c3) q3.push_back(e3);
      @(posedge clk); #1;
   endtask

   // Monitor: outputs are combinational, compared mid-cycle on the falling edge.
   initial begin
      int n1 = 0, n3 = 0;
      logic [12:0] e;
      forever begin
         @(negedge clk);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (out1 !== e) begin
               failures++;
               $display("FAIL dut1_vec%0d got=%b exp=%b", n1, out1, e);
            end
            n1++;
         end
         if (q3.size() > 0) begin
            e = q3.pop_front();
            checks++;
            if (out3 !== e) begin
               failures++;
               $display("FAIL dut3_vec%0d got=%b exp=%b", n3, out3, e);
            end
            n3++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      // Reset holds every output low even with hazards present.
      set_lu(); dmem_req = 1'b1; br_taken_EX = 1'b1;
      go(1, ZERO, 1, ZERO);
      rst = 1'b0; idle();
      go(1, NORM, 1, NORM);

      // Load-use on rs1: one bubble, then run.
      set_lu();                                 go(1, LU, 0, ZERO);
      idle();                                   go(1, NORM, 0, ZERO);
      // Load-use on rs2 only.
      set_lu(); rs1_ID = 5'd7; rs2_ID = 5'd5;   go(1, LU, 0, ZERO);
      idle();                                   go(1, NORM, 0, ZERO);
      // rs2 matches but is not read.
      set_lu(); rs1_ID = 5'd7; rs2_ID = 5'd5; rs2_used_ID = 1'b0;
                                                go(1, NORM, 0, ZERO);
      // Load to x0 never stalls.
      set_lu(); rd_EX = 5'd0; rs1_ID = 5'd0;    go(1, NORM, 0, ZERO);
      // Redirect wins over load-use.
      set_lu(); br_taken_EX = 1'b1;             go(1, REDIR, 0, ZERO);
      idle();                                   go(1, NORM, 0, ZERO);

      // Data wait 4 cycles, fetch responds early in cycle 1.
      idle(); imem_read = 1'b1; dmem_req = 1'b1;
      imem_resp = 1'b1;                         go(1, 13'b00000_00_10_00_00, 0, ZERO);
      imem_resp = 1'b0;                         go(1, 13'b00000_00_00_00_10, 0, ZERO);
                                                go(1, 13'b00000_00_00_00_10, 0, ZERO);
      dmem_resp = 1'b1;                         go(1, 13'b11111_00_01_00_10, 0, ZERO);
      idle();                                   go(1, NORM, 0, ZERO);

      // Fetch wait with early data response; load-use present while frozen and after release.
      idle(); imem_read = 1'b1; dmem_req = 1'b1;
      dmem_resp = 1'b1;                         go(1, 13'b00000_00_00_10_00, 0, ZERO);
      dmem_resp = 1'b0; set_lu();               go(1, 13'b00000_00_00_00_01, 0, ZERO);
      imem_resp = 1'b1;                         go(1, 13'b00111_10_00_01_01, 0, ZERO);
      idle();                                   go(1, NORM, 0, ZERO);

      // Reset while a fetch response is already captured.
      idle(); imem_read = 1'b1; dmem_req = 1'b1;
      imem_resp = 1'b1;                         go(1, 13'b00000_00_10_00_00, 0, ZERO);
      imem_resp = 1'b0; rst = 1'b1;             go(1, ZERO, 0, ZERO);
      rst = 1'b0; dmem_req = 1'b0;              go(1, ZERO, 0, ZERO);
      imem_resp = 1'b1;                         go(1, NORM, 0, ZERO);

      // Three-bubble instance.
      idle(); rst = 1'b1;                       go(0, ZERO, 1, ZERO);
      rst = 1'b0;                               go(0, ZERO, 1, NORM);
      set_lu();                                 go(0, ZERO, 1, LU);
      idle();                                   go(0, ZERO, 1, LU);
                                                go(0, ZERO, 1, LU);
                                                go(0, ZERO, 1, NORM);
      // Redirect on the second bubble aborts the sequence.
      set_lu();                                 go(0, ZERO, 1, LU);
      idle(); br_taken_EX = 1'b1;               go(0, ZERO, 1, REDIR);
      br_taken_EX = 1'b0;                       go(0, ZERO, 1, NORM);
                                                go(0, ZERO, 1, NORM);
      idle();
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (q1.size() != 0 || q3.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d/%0d exp=0/0", q1.size(), q3.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
